forwarding_hazard_unit: RTL and testbench

//  Combined forwarding and load-use hazard unit for the 5-stage MIPS pipeline, generalised over source-operand count.

---
 rtl/pipeline_pkg.sv | 33 +++
 rtl/fwd_src_match.sv | 35 +++
 rtl/forwarding_hazard_unit.sv | 145 ++++++++++++++
 tb/tb_forwarding_hazard_unit.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: forward-select encodings, hazard FSM states,
// per-operand compare result and the nearest-producer selection rule.
package pipeline_pkg;

    localparam logic [1:0] FWD_NONE  = 2'b00;
    localparam logic [1:0] FWD_MEMWB = 2'b01;
    localparam logic [1:0] FWD_EXMEM = 2'b10;

    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } hz_state_t;

    // Result of comparing one ID source operand against the in-flight destinations.
    typedef struct packed {
        logic hit_ex;
        logic hit_mem;
        logic load_hit;
    } src_hit_t;

    // Nearest producer wins: the EX instruction is younger than the MEM one.
    function automatic logic [1:0] fwd_select(input src_hit_t h);
        logic [1:0] sel;
        sel = FWD_NONE;
        if (h.hit_ex) begin
            sel = FWD_EXMEM;
        end else if (h.hit_mem) begin
            sel = FWD_MEMWB;
        end
        return sel;
    endfunction

endpackage

// File: rtl/fwd_src_match.sv
// Combinational compare of one ID source operand against the EX and MEM destinations.
module fwd_src_match
    import pipeline_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] src,
    input  logic                  src_used,
    input  logic [REG_ADDR_W-1:0] idex_rd,
    input  logic                  idex_reg_write,
    input  logic                  idex_mem_read,
    input  logic [REG_ADDR_W-1:0] exmem_rd,
    input  logic                  exmem_reg_write,
    output logic                  hit_ex_c,
    output logic                  hit_mem_c,
    output logic                  load_hit_c
);

    logic reads_c;
    logic ex_same_c;
    logic mem_same_c;

    // Register $0 is hard-wired to zero, so it never forwards or hazards.
    always_comb begin
        reads_c    = id_valid & src_used & (src != '0);
        ex_same_c  = reads_c & (idex_rd == src);
        mem_same_c = reads_c & (exmem_rd == src);

        hit_ex_c   = ex_same_c & idex_reg_write & ~idex_mem_read;
        load_hit_c = ex_same_c & idex_reg_write & idex_mem_read;
        hit_mem_c  = mem_same_c & exmem_reg_write;
    end

endmodule

// File: rtl/forwarding_hazard_unit.sv
// Forwarding and load-use hazard unit for the 5-stage pipeline.
// Forward selects are registered in ID so they are ready when the instruction
// reaches EX; load-use hazards stall PC/IF-ID and bubble ID/EX.
module forwarding_hazard_unit
    import pipeline_pkg::*;
#(
    parameter int unsigned REG_ADDR_W   = 5,
    parameter int unsigned NUM_SRC      = 2,
    parameter int unsigned STALL_CYCLES = 1,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          id_valid,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] id_src,
    input  logic [NUM_SRC-1:0]            id_src_used,
    input  logic [REG_ADDR_W-1:0]         idex_rd,
    input  logic                          idex_reg_write,
    input  logic                          idex_mem_read,
    input  logic [REG_ADDR_W-1:0]         exmem_rd,
    input  logic                          exmem_reg_write,
    input  logic                          flush,
    output logic [2*NUM_SRC-1:0]          fwd_sel,
    output logic                          stall,
    output logic                          idex_bubble,
    output logic [CNT_W-1:0]              stall_cnt
);

    localparam int unsigned FWD_W       = 2 * NUM_SRC;
    localparam bit          MULTI_CYCLE = (STALL_CYCLES > 32'd1);
    localparam logic [1:0]  REM_INIT    = 2'(STALL_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [NUM_SRC-1:0] hit_ex_c;
    logic [NUM_SRC-1:0] hit_mem_c;
    logic [NUM_SRC-1:0] load_hit_c;

    logic               hazard_c;
    logic               stall_c;
    hz_state_t          state;
    hz_state_t          state_n;
    logic [1:0]         remaining;
    logic [1:0]         remaining_n;
    logic [FWD_W-1:0]   fwd_next_c;

    // One comparator per source operand.
    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        fwd_src_match #(
            .REG_ADDR_W (REG_ADDR_W)
        ) u_match (
            .id_valid        (id_valid),
            .src             (id_src[g*REG_ADDR_W +: REG_ADDR_W]),
            .src_used        (id_src_used[g]),
            .idex_rd         (idex_rd),
            .idex_reg_write  (idex_reg_write),
            .idex_mem_read   (idex_mem_read),
            .exmem_rd        (exmem_rd),
            .exmem_reg_write (exmem_reg_write),
            .hit_ex_c        (hit_ex_c[g]),
            .hit_mem_c       (hit_mem_c[g]),
            .load_hit_c      (load_hit_c[g])
        );
    end

    // A squashed ID instruction cannot cause a load-use stall.
    assign hazard_c = ~flush & (|load_hit_c);

    // Stall FSM next-state: IDLE raises stall on a hazard, STALL counts down the extra cycles.
    always_comb begin
        state_n     = state;
        remaining_n = remaining;
        stall_c     = 1'b0;
        unique case (state)
            IDLE: begin
                stall_c = hazard_c;
                if (hazard_c && MULTI_CYCLE) begin
                    remaining_n = REM_INIT;
                    state_n     = STALL;
                end
            end
            STALL: begin
                if (flush) begin
                    remaining_n = 2'd0;
                    state_n     = IDLE;
                end else begin
                    stall_c     = 1'b1;
                    remaining_n = remaining - 2'd1;
                    if (remaining == 2'd1) begin
                        state_n = IDLE;
                    end
                end
            end
            default: begin
                remaining_n = 2'd0;
                state_n     = IDLE;
            end
        endcase
    end

    // Stall and bubble take effect in the same cycle; both are forced low during reset.
    assign stall       = stall_c & ~reset;
    assign idex_bubble = (stall_c | flush) & ~reset;

    // Stall FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            remaining <= 2'd0;
        end else begin
            state     <= state_n;
            remaining <= remaining_n;
        end
    end

    // Next forward selects; a bubble entering EX gets no forwarding.
    always_comb begin
        fwd_next_c = '0;
        if (!(stall_c || flush || !id_valid)) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                fwd_next_c[2*i +: 2] = fwd_select('{hit_ex:   hit_ex_c[i],
                                                    hit_mem:  hit_mem_c[i],
                                                    load_hit: load_hit_c[i]});
            end
        end
    end

    // Forward-select register, consumed by the instruction entering EX.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fwd_sel <= '0;
        end else begin
            fwd_sel <= fwd_next_c;
        end
    end

    // Saturating count of stalled cycles.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (stall_c && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// Bench for forwarding_hazard_unit: three builds (1-cycle stall, 3-cycle stall,
// 4-bit counter) share one stimulus stream and are checked against a model.
module tb_forwarding_hazard_unit;

    localparam int unsigned RW = 5;
    localparam int unsigned NS = 2;

    logic           clock = 1'b0;
    logic           reset;
    logic           id_valid;
    logic [NS*RW-1:0] id_src;
    logic [NS-1:0]  id_src_used;
    logic [RW-1:0]  idex_rd;
    logic           idex_reg_write;
    logic           idex_mem_read;
    logic [RW-1:0]  exmem_rd;
    logic           exmem_reg_write;
    logic           flush;

    logic [2*NS-1:0] fwd_o [3];
    logic [2:0]      stall_o;
    logic [2:0]      bub_o;
    logic [15:0]     cnt_a;
    logic [15:0]     cnt_b;
    logic [3:0]      cnt_c;

    int checks   = 0;
    int failures = 0;

    // Reference model state, one entry per build.
    int         m_left  [3];
    int         m_cnt   [3];
    logic [3:0] m_fwd   [3];
    logic       m_stall [3];
    logic       m_bub   [3];
    logic       m_hazard;
    int         m_cycles [3] = '{1, 3, 1};
    int         m_max    [3] = '{65535, 65535, 15};

    always #5 clock = ~clock;

    forwarding_hazard_unit #(.REG_ADDR_W(RW), .NUM_SRC(NS), .STALL_CYCLES(1), .CNT_W(16)) u_s1 (
        .clock(clock), .reset(reset), .id_valid(id_valid), .id_src(id_src),
        .id_src_used(id_src_used), .idex_rd(idex_rd), .idex_reg_write(idex_reg_write),
        .idex_mem_read(idex_mem_read), .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write),
        .flush(flush), .fwd_sel(fwd_o[0]), .stall(stall_o[0]), .idex_bubble(bub_o[0]),
        .stall_cnt(cnt_a));

    forwarding_hazard_unit #(.REG_ADDR_W(RW), .NUM_SRC(NS), .STALL_CYCLES(3), .CNT_W(16)) u_s3 (
        .clock(clock), .reset(reset), .id_valid(id_valid), .id_src(id_src),
        .id_src_used(id_src_used), .idex_rd(idex_rd), .idex_reg_write(idex_reg_write),
        .idex_mem_read(idex_mem_read), .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write),
        .flush(flush), .fwd_sel(fwd_o[1]), .stall(stall_o[1]), .idex_bubble(bub_o[1]),
        .stall_cnt(cnt_b));

    forwarding_hazard_unit #(.REG_ADDR_W(RW), .NUM_SRC(NS), .STALL_CYCLES(1), .CNT_W(4)) u_c4 (
        .clock(clock), .reset(reset), .id_valid(id_valid), .id_src(id_src),
        .id_src_used(id_src_used), .idex_rd(idex_rd), .idex_reg_write(idex_reg_write),
        .idex_mem_read(idex_mem_read), .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write),
        .flush(flush), .fwd_sel(fwd_o[2]), .stall(stall_o[2]), .idex_bubble(bub_o[2]),
        .stall_cnt(cnt_c));

    function automatic logic [RW-1:0] src_of(input int i);
        return id_src[i*RW +: RW];
    endfunction

    function automatic bit reads(input int i);
        return id_valid && id_src_used[i] && (src_of(i) != 0);
    endfunction

    function automatic int act_cnt(input int k);
        if (k == 0) return int'(cnt_a);
        if (k == 1) return int'(cnt_b);
        return int'(cnt_c);
    endfunction

    // Model of this cycle's stall/bubble from the current inputs.
    task automatic model_comb();
        m_hazard = 1'b0;
        for (int i = 0; i < NS; i++) begin
            if (reads(i) && idex_mem_read && idex_reg_write && idex_rd == src_of(i))
                m_hazard = 1'b1;
        end
        if (flush) m_hazard = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (reset) begin
                m_stall[k] = 1'b0;
                m_bub[k]   = 1'b0;
            end else begin
                m_stall[k] = (m_left[k] > 0) ? !flush : m_hazard;
                m_bub[k]   = m_stall[k] | flush;
            end
        end
    endtask

    // Advance one clock and update the model's registered view.
    task automatic tick();
        logic [1:0] sel;
        model_comb();
        @(posedge clock);
        for (int k = 0; k < 3; k++) begin
            if (reset) begin
                m_left[k] = 0;
                m_cnt[k]  = 0;
                m_fwd[k]  = '0;
            end else begin
                if (m_stall[k] && m_cnt[k] < m_max[k]) m_cnt[k]++;
                if (m_left[k] > 0) m_left[k] = flush ? 0 : m_left[k] - 1;
                else if (m_hazard) m_left[k] = m_cycles[k] - 1;
                m_fwd[k] = '0;
                if (!(m_stall[k] || flush || !id_valid)) begin
                    for (int i = 0; i < NS; i++) begin
                        sel = 2'b00;
                        if (reads(i) && exmem_reg_write && exmem_rd == src_of(i)) sel = 2'b01;
                        if (reads(i) && idex_reg_write && !idex_mem_read && idex_rd == src_of(i)) sel = 2'b10;
                        m_fwd[k][2*i +: 2] = sel;
                    end
                end
            end
        end
        #1;
    endtask

    task automatic drive(input logic v, input logic [RW-1:0] s1, input logic [RW-1:0] s0,
                         input logic [1:0] used, input logic [RW-1:0] xr, input logic xw,
                         input logic xm, input logic [RW-1:0] mr, input logic mw, input logic fl);
        id_valid        = v;
        id_src          = {s1, s0};
        id_src_used     = used;
        idex_rd         = xr;
        idex_reg_write  = xw;
        idex_mem_read   = xm;
        exmem_rd        = mr;
        exmem_reg_write = mw;
        flush           = fl;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            m_left[k] = 0; m_cnt[k] = 0; m_fwd[k] = '0;
        end
        #2;
        tick();
        tick();
        checks++;
        if (fwd_o[0] !== 4'b0 || fwd_o[1] !== 4'b0 || stall_o !== 3'b0 || bub_o !== 3'b0 ||
            cnt_a !== 16'd0 || cnt_b !== 16'd0 || cnt_c !== 4'd0) begin
            failures++;
            $display("FAIL reset_hold: fwd=%b/%b stall=%b bub=%b cnt=%0d/%0d/%0d expected all 0",
                     fwd_o[0], fwd_o[1], stall_o, bub_o, cnt_a, cnt_b, cnt_c);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (stall_o !== 3'b0 || bub_o !== 3'b0) begin
            failures++;
            $display("FAIL reset_release: stall=%b bub=%b expected 000/000", stall_o, bub_o);
        end
        tick();
    endtask

    task automatic test_alu_forward();
        drive(1'b1, 5'd0, 5'd3, 2'b01, 5'd3, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        #1;
        checks++;
        if (stall_o !== 3'b000) begin
            failures++;
            $display("FAIL alu_fwd_stall: stall=%b expected 000", stall_o);
        end
        tick();
        checks++;
        if (fwd_o[0] !== 4'b0010) begin
            failures++;
            $display("FAIL alu_fwd_sel: fwd_sel=%b expected 0010", fwd_o[0]);
        end
    endtask

    task automatic test_nearest_wins();
        drive(1'b1, 5'd4, 5'd4, 2'b11, 5'd4, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0);
        tick();
        checks++;
        if (fwd_o[0] !== 4'b1010) begin
            failures++;
            $display("FAIL nearest_wins: fwd_sel=%b expected 1010", fwd_o[0]);
        end
        drive(1'b1, 5'd0, 5'd0, 2'b11, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0);
        tick();
        checks++;
        if (fwd_o[0] !== 4'b0000) begin
            failures++;
            $display("FAIL zero_reg: fwd_sel=%b expected 0000", fwd_o[0]);
        end
        drive(1'b1, 5'd7, 5'd9, 2'b11, 5'd2, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0);
        tick();
        checks++;
        if (fwd_o[0] !== 4'b0100) begin
            failures++;
            $display("FAIL mem_only: fwd_sel=%b expected 0100", fwd_o[0]);
        end
    endtask

    task automatic test_load_use();
        drive(1'b1, 5'd5, 5'd0, 2'b10, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
        #1;
        checks++;
        if (stall_o[0] !== 1'b1 || bub_o[0] !== 1'b1) begin
            failures++;
            $display("FAIL load_use_stall: stall=%b bubble=%b expected 1/1", stall_o[0], bub_o[0]);
        end
        tick();
        drive(1'b1, 5'd5, 5'd0, 2'b10, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0);
        #1;
        checks++;
        if (stall_o[0] !== 1'b0 || bub_o[0] !== 1'b0 || fwd_o[0][3:2] !== 2'b00) begin
            failures++;
            $display("FAIL load_use_release: stall=%b bubble=%b fwd=%b expected 0/0/00",
                     stall_o[0], bub_o[0], fwd_o[0][3:2]);
        end
        tick();
        checks++;
        if (fwd_o[0][3:2] !== 2'b01 || cnt_a !== 16'd1) begin
            failures++;
            $display("FAIL load_use_fwd: fwd=%b cnt=%0d expected 01/1", fwd_o[0][3:2], cnt_a);
        end
        drive(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
        tick();
        tick();
    endtask

    task automatic test_multi_cycle_stall();
        drive(1'b1, 5'd0, 5'd6, 2'b01, 5'd6, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++;
            if (stall_o[1] !== (c < 3)) begin
                failures++;
                $display("FAIL stall3_cycle%0d: stall=%b expected %b", c, stall_o[1], c < 3);
            end
            tick();
            drive(1'b1, 5'd0, 5'd6, 2'b01, 5'd0, 1'b0, 1'b0, 5'd6, 1'b1, 1'b0);
        end
        drive(1'b1, 5'd0, 5'd6, 2'b01, 5'd6, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd0, 5'd6, 2'b01, 5'd0, 1'b0, 1'b0, 5'd6, 1'b1, 1'b1);
        #1;
        checks++;
        if (stall_o[1] !== 1'b0 || bub_o[1] !== 1'b1) begin
            failures++;
            $display("FAIL stall3_flush: stall=%b bubble=%b expected 0/1", stall_o[1], bub_o[1]);
        end
        tick();
        drive(1'b1, 5'd0, 5'd6, 2'b01, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        #1;
        checks++;
        if (stall_o[1] !== 1'b0 || bub_o[1] !== 1'b0) begin
            failures++;
            $display("FAIL stall3_after_flush: stall=%b bubble=%b expected 0/0", stall_o[1], bub_o[1]);
        end
        tick();
    endtask

    task automatic test_reset_mid_stall();
        drive(1'b1, 5'd0, 5'd8, 2'b01, 5'd8, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd0, 5'd8, 2'b01, 5'd0, 1'b0, 1'b0, 5'd8, 1'b1, 1'b0);
        #1;
        checks++;
        if (stall_o[1] !== 1'b1) begin
            failures++;
            $display("FAIL mid_stall_pre: stall=%b expected 1", stall_o[1]);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (stall_o !== 3'b0 || bub_o !== 3'b0 || fwd_o[1] !== 4'b0 || cnt_b !== 16'd0) begin
            failures++;
            $display("FAIL async_reset: stall=%b bub=%b fwd=%b cnt=%0d expected 0",
                     stall_o, bub_o, fwd_o[1], cnt_b);
        end
        drive(1'b1, 5'd0, 5'd8, 2'b01, 5'd8, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
        #1;
        checks++;
        if (stall_o !== 3'b0 || bub_o !== 3'b0) begin
            failures++;
            $display("FAIL reset_gate: stall=%b bub=%b expected 000/000", stall_o, bub_o);
        end
        tick();
        drive(1'b1, 5'd0, 5'd8, 2'b01, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        #2 reset = 1'b0;
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++;
            if (stall_o !== 3'b0) begin
                failures++;
                $display("FAIL post_reset%0d: stall=%b expected 000", c, stall_o);
            end
            tick();
        end
    endtask

    task automatic test_saturation();
        int exp_cnt;
        drive(1'b1, 5'd0, 5'd9, 2'b01, 5'd9, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
        for (int n = 1; n <= 19; n++) begin
            tick();
            exp_cnt = (n < 15) ? n : 15;
            checks++;
            if (int'(cnt_c) != exp_cnt) begin
                failures++;
                $display("FAIL sat_cnt_%0d: stall_cnt=%0d expected %0d", n, cnt_c, exp_cnt);
            end
        end
        checks++;
        if (cnt_c !== 4'hF) begin
            failures++;
            $display("FAIL sat_final: stall_cnt=%h expected f", cnt_c);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 7) != 0), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  2'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 7) == 0));
            #1;
            model_comb();
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (stall_o[k] !== m_stall[k] || bub_o[k] !== m_bub[k]) begin
                    failures++;
                    $display("FAIL rand_comb dut%0d cyc%0d: stall=%b bub=%b expected %b/%b",
                             k, n, stall_o[k], bub_o[k], m_stall[k], m_bub[k]);
                end
            end
            tick();
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (fwd_o[k] !== m_fwd[k] || act_cnt(k) != m_cnt[k]) begin
                    failures++;
                    $display("FAIL rand_reg dut%0d cyc%0d: fwd=%b cnt=%0d expected %b/%0d",
                             k, n, fwd_o[k], act_cnt(k), m_fwd[k], m_cnt[k]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_alu_forward();
        test_nearest_wins();
        test_load_use();
        test_multi_cycle_stall();
        test_reset_mid_stall();
        test_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
